// File: rtl/dct_serial_rx.sv
// rtl/dct_serial_rx.sv - bit-serial DCT coefficient deserializer with block framing and output FIFO
//
// Purpose:
//   Rebuilds DATA_W-bit coefficients (MSB first) from the DCT core's serial
//   stream. Tags the final coefficient of each block using the block length
//   latched from iSize. Buffers completed words in a show-ahead FIFO.
//   Optional feature macro: DCT_RX_BLKCNT_EN adds the oBlkCnt block counter.
//
// Ports:
//   iClk, iRst      clock, synchronous active-high reset
//   iSDAT, iSVAL    serial data bit and its valid strobe
//   iSize           transform size code (0=4, 1=8, 2=16, 3..7=32 points)
//   oData, oLast    FIFO head coefficient and its end-of-block flag
//   oValid, iReady  head valid / consumer accept (pop on oValid & iReady)
//   oOvf, oFrmErr   sticky overflow and framing-error flags
//   oBusy           high while a word or block is in progress
//   oBlkCnt         (DCT_RX_BLKCNT_EN only) count of completed blocks
module dct_serial_rx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iSDAT,
  input  logic              iSVAL,
  input  logic [2:0]        iSize,
  output logic [DATA_W-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oLast,
  output logic              oOvf,
  output logic              oFrmErr,
`ifdef DCT_RX_BLKCNT_EN
  output logic [15:0]       oBlkCnt,
`endif
  output logic              oBusy
);

  localparam int BW = $clog2(DATA_W);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       bitcnt_q, bitcnt_d;
  logic [4:0]          coefcnt_q, coefcnt_d;
  logic [4:0]          lastidx_q, lastidx_d;
  // Holds the DATA_W-1 bits received so far; the final bit comes straight from iSDAT.
  logic [DATA_W-2:0]   shreg_q, shreg_d;
  logic [DATA_W:0]     mem_q [FIFO_DEPTH];
  logic [DATA_W:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                frmerr_q, frmerr_d;
`ifdef DCT_RX_BLKCNT_EN
  logic [15:0]         blkcnt_q, blkcnt_d;
`endif

  logic                word_done, word_last, pop, full, push_ok;
  logic [DATA_W-1:0]   word_data;

  function automatic logic [4:0] last_idx_of(input logic [2:0] sz);
    case (sz)
      3'd0:    return 5'd3;
      3'd1:    return 5'd7;
      3'd2:    return 5'd15;
      default: return 5'd31;
    endcase
  endfunction

  // Deserializer datapath
  always_comb begin
    bitcnt_d  = bitcnt_q;
    coefcnt_d = coefcnt_q;
    lastidx_d = lastidx_q;
    shreg_d   = shreg_q;
    frmerr_d  = frmerr_q;
    word_done = 1'b0;
    word_last = (coefcnt_q == lastidx_q);
    word_data = {shreg_q, iSDAT};
    case (state_q)
      S_IDLE: begin
        if (iSVAL) begin
          lastidx_d = last_idx_of(iSize);
          shreg_d   = (DATA_W-1)'(iSDAT);
          bitcnt_d  = BW'(1);
        end
      end
      default: begin
        if (iSVAL) begin
          shreg_d = word_data[DATA_W-2:0];
          if (bitcnt_q == BIT_LAST) begin
            word_done = 1'b1;
            bitcnt_d  = '0;
            coefcnt_d = word_last ? 5'd0 : coefcnt_q + 5'd1;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end else if (bitcnt_q != '0) begin
          // Valid dropped mid-word: throw away the partial word but keep the block position.
          frmerr_d = 1'b1;
          bitcnt_d = '0;
        end
      end
    endcase
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (iSVAL) state_d = S_SHIFT;
      default: if (word_done && word_last) state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    oBusy = (state_q == S_SHIFT);
  end

  // Output FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
  always_comb begin
    pop     = (count_q != '0) && iReady;
    full    = (count_q == CNT_FULL);
    push_ok = word_done && (!full || pop);
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    ovf_d   = ovf_q;
    if (push_ok) begin
      mem_d[wptr_q] = {word_last, word_data};
      wptr_d        = wptr_q + PW'(1);
    end
    if (word_done && !push_ok) ovf_d = 1'b1;
    if (pop) rptr_d = rptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop);
`ifdef DCT_RX_BLKCNT_EN
    // Counts block ends even when the final word itself was dropped.
    blkcnt_d = blkcnt_q + ((word_done && word_last) ? 16'd1 : 16'd0);
`endif
  end

  always_ff @(posedge iClk) begin
    mem_q <= mem_d;
    if (iRst) begin
      state_q   <= S_IDLE;
      bitcnt_q  <= '0;
      coefcnt_q <= '0;
      lastidx_q <= '0;
      shreg_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      frmerr_q  <= 1'b0;
`ifdef DCT_RX_BLKCNT_EN
      blkcnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      coefcnt_q <= coefcnt_d;
      lastidx_q <= lastidx_d;
      shreg_q   <= shreg_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      frmerr_q  <= frmerr_d;
`ifdef DCT_RX_BLKCNT_EN
      blkcnt_q  <= blkcnt_d;
`endif
    end
  end

  // Head outputs are forced to zero while empty so reset leaves every output at 0.
  assign oValid  = (count_q != '0);
  assign oData   = oValid ? mem_q[rptr_q][DATA_W-1:0] : '0;
  assign oLast   = oValid ? mem_q[rptr_q][DATA_W] : 1'b0;
  assign oOvf    = ovf_q;
  assign oFrmErr = frmerr_q;
`ifdef DCT_RX_BLKCNT_EN
  assign oBlkCnt = blkcnt_q;
`endif

endmodule

// File: tb/tb_dct_serial_rx.sv
// tb/tb_dct_serial_rx.sv - directed/randomized self-checking bench for dct_serial_rx
module tb_dct_serial_rx;

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iSDAT = 1'b0;
  logic        iSVAL = 1'b0;
  logic [2:0]  iSize = 3'd0;
  logic        iReady = 1'b0;
  logic [15:0] oData;
  logic        oValid, oLast, oOvf, oFrmErr, oBusy;
`ifdef DCT_RX_BLKCNT_EN
  logic [15:0] oBlkCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] got[$];
  logic [16:0] exp_q[$];

  dct_serial_rx #(.DATA_W(16), .FIFO_DEPTH(8)) dut (
    .iClk(iClk), .iRst(iRst), .iSDAT(iSDAT), .iSVAL(iSVAL), .iSize(iSize),
    .oData(oData), .oValid(oValid), .iReady(iReady), .oLast(oLast),
    .oOvf(oOvf), .oFrmErr(oFrmErr),
`ifdef DCT_RX_BLKCNT_EN
    .oBlkCnt(oBlkCnt),
`endif
    .oBusy(oBusy)
  );

  always #5 iClk = ~iClk;

  // Record every word the consumer takes; the pop happens on the next rising edge.
  always @(negedge iClk) begin
    if (!iRst && oValid === 1'b1 && iReady === 1'b1) got.push_back({oLast, oData});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int blk_len(input logic [2:0] sz);
    case (sz)
      3'd0:    return 4;
      3'd1:    return 8;
      3'd2:    return 16;
      default: return 32;
    endcase
  endfunction

  task automatic send_range(input logic [15:0] w, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      iSVAL = 1'b1;
      iSDAT = w[b];
      step();
    end
    iSVAL = 1'b0;
    iSDAT = 1'b0;
  endtask

  task automatic idle(input int n);
    iSVAL = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    idle(gap);
    send_range(w, 15, 0);
  endtask

  // One whole block of random words; iSize is scrambled after the first word
  // because the latched length must hold for the rest of the block.
  task automatic send_block(input logic [2:0] sz, input int maxgap);
    int          len;
    logic [15:0] w;
    len   = blk_len(sz);
    iSize = sz;
    for (int i = 0; i < len; i++) begin
      w = 16'($urandom);
      send_word(w, (i == 0) ? 0 : int'($urandom_range(0, maxgap)));
      exp_q.push_back({(i == len - 1), w});
      if (i == 0) iSize = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic drain();
    iReady = 1'b1;
    for (int k = 0; k < 64 && oValid === 1'b1; k++) step();
    check("drain_empty", {31'd0, oValid}, 32'd0);
  endtask

  task automatic check_queue(input string tag);
    check($sformatf("%s_count", tag), got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check($sformatf("%s_word%0d", tag, i), {15'd0, got[i]}, {15'd0, exp_q[i]});
    got.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    iRst  = 1'b1;
    iSVAL = 1'b0;
    step();
    step();
    iRst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, oValid}, 32'd0);
    check({tag, "_data"}, {16'd0, oData}, 32'd0);
    check({tag, "_last"}, {31'd0, oLast}, 32'd0);
    check({tag, "_ovf"}, {31'd0, oOvf}, 32'd0);
    check({tag, "_frmerr"}, {31'd0, oFrmErr}, 32'd0);
    check({tag, "_busy"}, {31'd0, oBusy}, 32'd0);
`ifdef DCT_RX_BLKCNT_EN
    check({tag, "_blkcnt"}, {16'd0, oBlkCnt}, 32'd0);
`endif
  endtask

  initial begin
    logic [15:0] ws[10];
    logic [15:0] w;

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Fixed 4-word block, back-to-back, with first-word latency
    iSize  = 3'd0;
    iReady = 1'b1;
    send_range(16'h1234, 15, 1);
    check("lat_before_last_bit", {31'd0, oValid}, 32'd0);
    check("busy_mid_word", {31'd0, oBusy}, 32'd1);
    send_range(16'h1234, 0, 0);
    check("lat_after_last_bit", {31'd0, oValid}, 32'd1);
    check("lat_head_data", {16'd0, oData}, 32'h1234);
    send_word(16'h8001, 0);
    send_word(16'h00FF, 0);
    send_word(16'hFFFF, 0);
    check("busy_after_block", {31'd0, oBusy}, 32'd0);
    exp_q.push_back({1'b0, 16'h1234});
    exp_q.push_back({1'b0, 16'h8001});
    exp_q.push_back({1'b0, 16'h00FF});
    exp_q.push_back({1'b1, 16'hFFFF});
    idle(2);
    drain();
    check_queue("basic");

    // 32-word block with random gaps, then an 8-word block
    send_block(3'd3, 3);
    send_block(3'd1, 3);
    idle(2);
    drain();
    check_queue("gaps");

    // Overflow with consumer stalled; framing survives dropped words
    iReady = 1'b0;
    iSize  = 3'd3;
    for (int i = 0; i < 10; i++) begin
      ws[i] = 16'($urandom);
      send_word(ws[i], 0);
      if (i < 8) exp_q.push_back({1'b0, ws[i]});
      if (i == 7) check("ovf_clear_at_8", {31'd0, oOvf}, 32'd0);
      if (i == 8) check("ovf_set_at_9", {31'd0, oOvf}, 32'd1);
    end
    drain();
    check_queue("ovf_held");
    for (int i = 10; i < 32; i++) begin
      w = 16'($urandom);
      send_word(w, int'($urandom_range(0, 1)));
      exp_q.push_back({(i == 31), w});
    end
    send_block(3'd0, 2);
    idle(2);
    drain();
    check_queue("ovf_reframe");
    check("ovf_sticky", {31'd0, oOvf}, 32'd1);

    // Framing error mid-word
    do_reset();
    iReady = 1'b1;
    iSize  = 3'd0;
    w = 16'($urandom);
    send_word(w, 0);
    exp_q.push_back({1'b0, w});
    send_range(16'($urandom), 15, 11);
    step();
    check("frmerr_set", {31'd0, oFrmErr}, 32'd1);
    check("frmerr_busy", {31'd0, oBusy}, 32'd1);
    send_word(16'hA5A5, 1);
    exp_q.push_back({1'b0, 16'hA5A5});
    for (int i = 2; i < 4; i++) begin
      w = 16'($urandom);
      send_word(w, 0);
      exp_q.push_back({(i == 3), w});
    end
    idle(2);
    drain();
    check_queue("frmerr");
    check("frmerr_sticky", {31'd0, oFrmErr}, 32'd1);

    // Full FIFO with a same-cycle pop: no drop, still holding 8 afterwards
    do_reset();
    iReady = 1'b0;
    iSize  = 3'd3;
    for (int i = 0; i < 8; i++) begin
      ws[i] = 16'($urandom);
      send_word(ws[i], 0);
      exp_q.push_back({1'b0, ws[i]});
    end
    ws[8] = 16'($urandom);
    send_range(ws[8], 15, 1);
    iReady = 1'b1;
    send_range(ws[8], 0, 0);
    iReady = 1'b0;
    exp_q.push_back({1'b0, ws[8]});
    check("full_pop_no_ovf", {31'd0, oOvf}, 32'd0);
    send_word(16'($urandom), 0);
    check("full_holds_8", {31'd0, oOvf}, 32'd1);
    drain();
    check_queue("fullpop");

    // Reset mid-word and mid-block
    iReady = 1'b0;
    iSize  = 3'd0;
    send_word(16'($urandom), 0);
    send_range(16'($urandom), 15, 9);
    step();
    send_range(16'($urandom), 15, 13);
    check("pre_rst_valid", {31'd0, oValid}, 32'd1);
    check("pre_rst_frmerr", {31'd0, oFrmErr}, 32'd1);
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    check_all_zero("midrst");
    got.delete();
    iReady = 1'b1;
    send_block(3'd0, 2);
    idle(2);
    drain();
    check_queue("post_rst");
`ifdef DCT_RX_BLKCNT_EN
    check("blkcnt_one", {16'd0, oBlkCnt}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
